// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//   Shared definitions for the program loader: FSM state encoding, the
//   default load address, the word geometry used by the byte packer, and a
//   helper that turns a requested base address into the aligned start address.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE   = 32'd128;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    // A zero base means "use the default"; the result is always word aligned.
    function automatic logic [31:0] load_addr(input logic [31:0] base,
                                              input logic [31:0] dflt);
        logic [31:0] a;
        a = (base == 32'd0) ? dflt : base;
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Assembles a 32-bit word from a byte stream, first byte in bits 31:24.
//
//   clk, reset  : clock, synchronous active-high reset
//   clear       : synchronous clear of the partial word and byte index
//   shift_en    : a byte is accepted this cycle
//   byte_in     : byte being accepted
//   word_full   : the byte accepted this cycle completes the word
//   word_next   : word as it will look after this cycle's shift; when
//                 word_full is high this is the complete assembled word
// -----------------------------------------------------------------------------
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word_next
);

    logic [31:0]           word;
    logic [BYTE_IDX_W-1:0] idx;

    assign word_next = {word[23:0], byte_in};
    assign word_full = shift_en && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    // The index is a power-of-two counter, so it wraps to 0 on its own when
    // the last byte of a word is shifted in.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            word <= word_next;
            idx  <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Loads a program into instruction memory from a byte stream. Bytes are
//   packed big-endian into 32-bit words, each word is written at consecutive
//   word addresses, and a running mod-2^32 checksum of written words is kept.
//
//   Parameters
//     DEFAULT_BASE : load address used when base_addr is 0
//     CNT_W        : width of word_count and the internal word counter
//
//   Ports
//     clk, reset              : clock, synchronous active-high reset
//     start, base_addr,
//     word_count              : load request (sampled only in IDLE)
//     abort                   : cancel a load in progress
//     byte_valid, byte_data,
//     byte_ready              : byte stream handshake
//     mem_we, mem_addr,
//     mem_wdata, mem_ack      : instruction memory write handshake
//     busy                    : not in IDLE
//     done                    : one-cycle pulse on successful completion
//     checksum                : sum of words written by the current/last load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter logic [31:0] DEFAULT_BASE = prog_loader_pkg::DEFAULT_BASE,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum
);

    import prog_loader_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] count;

    logic             pk_clear;
    logic             pk_shift;
    logic             pk_full;
    logic [31:0]      pk_word;

    // Partial words only live in COLLECT; holding the packer clear everywhere
    // else discards a half-built word on abort and restarts each word at
    // byte 0.
    assign pk_clear = (state != COLLECT);
    assign pk_shift = byte_ready && byte_valid && !abort;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .shift_en  (pk_shift),
        .byte_in   (byte_data),
        .word_full (pk_full),
        .word_next (pk_word)
    );

    // All outputs are registered and set together with the state transition
    // that makes them true, so they line up exactly with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        checksum <= '0;
                        busy     <= 1'b1;
                        if (word_count != '0) begin
                            state      <= COLLECT;
                            mem_addr   <= load_addr(base_addr, DEFAULT_BASE);
                            count      <= word_count;
                            byte_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (abort) begin
                        state      <= IDLE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (pk_full) begin
                        state      <= WRITE;
                        mem_wdata  <= pk_word;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                    end
                end

                WRITE: begin
                    // abort wins over a same-cycle ack: the word is dropped
                    // and not added to the checksum.
                    if (abort) begin
                        state  <= IDLE;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                    end else if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + 32'd4;
                        checksum <= checksum + mem_wdata;
                        count    <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
